// File: rtl/axil_pkg.sv
// Shared AXI-lite response codes and channel FSM state encodings.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

endpackage

// File: rtl/axil_reg_slave.sv
// AXI-lite responder holding REG_COUNT byte-strobed read/write registers.
// Read and write channels run as independent FSMs with registered handshake outputs.
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned           REG_COUNT  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  s_clk,
    input  logic                  s_rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready
);

    localparam int unsigned           IDX_W = $clog2(REG_COUNT);
    localparam int unsigned           OFF_W = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(REG_COUNT * STRB_WIDTH);

    // Returns {in_range, index}; addresses below BASE_ADDR wrap and fall out of range.
    function automatic logic [IDX_W:0] f_decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return {off < SPAN, off[OFF_W +: IDX_W]};
    endfunction

    logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];

    w_state_t              r_wstate;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;

    r_state_t              r_rstate;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_caddr;
    logic [DATA_WIDTH-1:0] w_cdata;
    logic [STRB_WIDTH-1:0] w_cstrb;
    logic [IDX_W:0]        w_cdec;
    logic [IDX_W:0]        w_rdec;
    logic                  w_unused;

    assign w_unused = ^{s_axil_awprot, s_axil_arprot};
    assign w_aw_hs  = s_axil_awvalid && r_awready;
    assign w_w_hs   = s_axil_wvalid && r_wready;

    // Commit source: live bus fields, or whichever half was latched in an earlier cycle.
    always_comb begin
        w_commit = 1'b0;
        w_caddr  = s_axil_awaddr;
        w_cdata  = s_axil_wdata;
        w_cstrb  = s_axil_wstrb;
        case (r_wstate)
            W_IDLE: w_commit = w_aw_hs && w_w_hs;
            W_ADDR: begin
                w_commit = w_w_hs;
                w_caddr  = r_awaddr;
            end
            W_DATA: begin
                w_commit = w_aw_hs;
                w_cdata  = r_wdata;
                w_cstrb  = r_wstrb;
            end
            default: ;
        endcase
    end

    assign w_cdec = f_decode(w_caddr);
    assign w_rdec = f_decode(s_axil_araddr);

    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) begin
            r_wstate  <= W_IDLE;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else if (w_commit) begin
            r_wstate  <= W_RESP;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_cdec[IDX_W] ? RESP_OKAY : RESP_SLVERR;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_wstate  <= W_ADDR;
                        r_awaddr  <= s_axil_awaddr;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                    end else if (w_w_hs) begin
                        r_wstate  <= W_DATA;
                        r_wdata   <= s_axil_wdata;
                        r_wstrb   <= s_axil_wstrb;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b0;
                    end else begin
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (s_axil_bready) begin
                        r_wstate  <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
        end else if (w_commit && w_cdec[IDX_W]) begin
            for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
                if (w_cstrb[b]) r_regs[w_cdec[IDX_W-1:0]][8*b +: 8] <= w_cdata[8*b +: 8];
            end
        end
    end

    // Sampling r_regs on the AR edge yields the pre-commit value on a same-cycle write.
    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (s_axil_arvalid && r_arready) begin
                        r_rstate  <= R_DATA;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rdec[IDX_W] ? r_regs[w_rdec[IDX_W-1:0]] : '0;
                        r_rresp   <= w_rdec[IDX_W] ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axil_rready) begin
                        r_rstate  <= R_IDLE;
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_axil_awready = r_awready;
    assign s_axil_wready  = r_wready;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_bresp   = r_bresp;
    assign s_axil_arready = r_arready;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_rresp   = r_rresp;
    assign s_axil_rdata   = r_rdata;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Scoreboard bench for axil_reg_slave: a register model predicts every B and R response,
// which is queued when stimulus is issued and compared when the DUT responds.
module tb_axil_reg_slave;

    logic        s_clk = 1'b0;
    logic        s_rst;
    logic [31:0] s_axil_awaddr;
    logic [2:0]  s_axil_awprot;
    logic        s_axil_awvalid;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_wvalid;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready;
    logic [31:0] s_axil_araddr;
    logic [2:0]  s_axil_arprot;
    logic        s_axil_arvalid;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready;

    axil_reg_slave #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .REG_COUNT (16),
        .BASE_ADDR (32'h0)
    ) dut (
        .s_clk          (s_clk),
        .s_rst          (s_rst),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awprot  (s_axil_awprot),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arprot  (s_axil_arprot),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready)
    );

    always #5 s_clk = ~s_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [1:0]  exp_bresp_q [$];
    logic [31:0] exp_rdata_q [$];
    logic [1:0]  exp_rresp_q [$];
    logic [31:0] model [16];

    task automatic sb_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if (addr < 32'h40) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[addr[5:2]][8*b +: 8] = data[8*b +: 8];
            exp_bresp_q.push_back(2'b00);
        end else begin
            exp_bresp_q.push_back(2'b10);
        end
    endtask

    task automatic sb_read(input logic [31:0] addr);
        if (addr < 32'h40) begin
            exp_rdata_q.push_back(model[addr[5:2]]);
            exp_rresp_q.push_back(2'b00);
        end else begin
            exp_rdata_q.push_back(32'h0);
            exp_rresp_q.push_back(2'b10);
        end
    endtask

    function automatic logic [1:0] pop_b();
        if (exp_bresp_q.size() == 0) return 2'bxx;
        return exp_bresp_q.pop_front();
    endfunction

    function automatic logic [33:0] pop_r();
        if (exp_rdata_q.size() == 0 || exp_rresp_q.size() == 0) return 34'bx;
        return {exp_rresp_q.pop_front(), exp_rdata_q.pop_front()};
    endfunction

    // Bus drivers: stimulus and response capture only, all checks live in the test tasks.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_delay, output logic [1:0] resp, output int lat, output bit to);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0; to = 0; lat = 0; resp = 2'bxx;
        s_axil_awaddr = addr; s_axil_awvalid = 1'b1;
        s_axil_wdata = data; s_axil_wstrb = strb; s_axil_wvalid = (w_delay == 0);
        while (!(aw_done && w_done) && cyc < 50) begin
            aw_hs = s_axil_awvalid && s_axil_awready;
            w_hs  = s_axil_wvalid && s_axil_wready;
            @(posedge s_clk); #1; cyc++;
            if (aw_hs) begin aw_done = 1; s_axil_awvalid = 1'b0; end
            if (w_hs) begin w_done = 1; s_axil_wvalid = 1'b0; end
            if (!w_done && !s_axil_wvalid && cyc >= w_delay) s_axil_wvalid = 1'b1;
        end
        if (!(aw_done && w_done)) begin
            to = 1; s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
            return;
        end
        while (!s_axil_bvalid && lat < 20) begin @(posedge s_clk); #1; lat++; end
        if (!s_axil_bvalid) begin to = 1; return; end
        resp = s_axil_bresp;
        s_axil_bready = 1'b1;
        @(posedge s_clk); #1;
        s_axil_bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                           output int lat, output bit to);
        int cyc;
        cyc = 0; lat = 0; to = 0; data = 'x; resp = 2'bxx;
        s_axil_araddr = addr; s_axil_arvalid = 1'b1;
        while (!s_axil_arready && cyc < 20) begin @(posedge s_clk); #1; cyc++; end
        if (!s_axil_arready) begin to = 1; s_axil_arvalid = 1'b0; return; end
        @(posedge s_clk); #1;
        s_axil_arvalid = 1'b0;
        while (!s_axil_rvalid && lat < 20) begin @(posedge s_clk); #1; lat++; end
        if (!s_axil_rvalid) begin to = 1; return; end
        data = s_axil_rdata; resp = s_axil_rresp;
        s_axil_rready = 1'b1;
        @(posedge s_clk); #1;
        s_axil_rready = 1'b0;
    endtask

    task automatic test_reset();
        s_rst = 1'b0;
        repeat (2) @(posedge s_clk);
        #1;
        n_cmp++;
        if ({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid,
             s_axil_bresp, s_axil_rresp, s_axil_rdata} !== 41'd0) begin
            n_fail++; $display("FAIL reset_outputs: got aw%b w%b ar%b b%b r%b rdata %h, expected all 0",
                s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid, s_axil_rdata);
        end
        s_rst = 1'b1;
        #1;
        n_cmp++;
        if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b000) begin
            n_fail++; $display("FAIL ready_before_edge: got %b expected 000",
                {s_axil_awready, s_axil_wready, s_axil_arready});
        end
        @(posedge s_clk); #1;
        n_cmp++;
        if ({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid} !== 5'b11100) begin
            n_fail++; $display("FAIL ready_after_edge: got %b expected 11100",
                {s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid});
        end
    endtask

    task automatic test_same_cycle_write();
        logic [1:0] resp, rr, eb; logic [31:0] rd; logic [33:0] er; int lat; bit to;
        sb_write(32'h04, 32'hDEADBEEF, 4'hF);
        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, resp, lat, to);
        eb = pop_b();
        n_cmp++;
        if (to || resp !== eb || lat != 0) begin
            n_fail++; $display("FAIL wr04: bresp %b lat %0d timeout %0d, expected bresp %b lat 0", resp, lat, to, eb);
        end
        sb_read(32'h04);
        do_read(32'h04, rd, rr, lat, to);
        er = pop_r();
        n_cmp++;
        if (to || {rr, rd} !== er || lat != 0) begin
            n_fail++; $display("FAIL rd04: rresp %b rdata %h lat %0d, expected rresp %b rdata %h lat 0",
                rr, rd, lat, er[33:32], er[31:0]);
        end
        sb_read(32'h07);
        do_read(32'h07, rd, rr, lat, to);
        er = pop_r();
        n_cmp++;
        if (to || {rr, rd} !== er) begin
            n_fail++; $display("FAIL rd07_lowbits: rresp %b rdata %h, expected %b %h", rr, rd, er[33:32], er[31:0]);
        end
    endtask

    task automatic test_aw_before_w();
        logic [1:0] resp, rr, eb; logic [31:0] rd; logic [33:0] er; int lat; bit to;
        logic [31:0] wdat [3];
        logic [3:0]  wstb [3];
        int          wdly [3];
        wdat = '{32'hFFFFFFFF, 32'h11223344, 32'h00000000};
        wstb = '{4'hF, 4'b0101, 4'h0};
        wdly = '{0, 3, 0};
        for (int i = 0; i < 3; i++) begin
            sb_write(32'h08, wdat[i], wstb[i]);
            do_write(32'h08, wdat[i], wstb[i], wdly[i], resp, lat, to);
            eb = pop_b();
            n_cmp++;
            if (to || resp !== eb || lat != 0) begin
                n_fail++; $display("FAIL wr08_step%0d: bresp %b lat %0d timeout %0d, expected %b lat 0",
                    i, resp, lat, to, eb);
            end
            sb_read(32'h08);
            do_read(32'h08, rd, rr, lat, to);
            er = pop_r();
            n_cmp++;
            if (to || {rr, rd} !== er) begin
                n_fail++; $display("FAIL rd08_step%0d: rdata %h rresp %b, expected %h %b",
                    i, rd, rr, er[31:0], er[33:32]);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp, rr, eb; logic [31:0] rd; logic [33:0] er; int lat; bit to;
        sb_write(32'h40, 32'hCAFEF00D, 4'hF);
        do_write(32'h40, 32'hCAFEF00D, 4'hF, 0, resp, lat, to);
        eb = pop_b();
        n_cmp++;
        if (to || resp !== eb) begin
            n_fail++; $display("FAIL wr40_slverr: bresp %b timeout %0d, expected %b", resp, to, eb);
        end
        sb_read(32'h40);
        do_read(32'h40, rd, rr, lat, to);
        er = pop_r();
        n_cmp++;
        if (to || {rr, rd} !== er) begin
            n_fail++; $display("FAIL rd40_slverr: rresp %b rdata %h, expected %b %h", rr, rd, er[33:32], er[31:0]);
        end
        for (int i = 0; i < 16; i++) begin
            sb_read(32'(i * 4));
            do_read(32'(i * 4), rd, rr, lat, to);
            er = pop_r();
            n_cmp++;
            if (to || {rr, rd} !== er) begin
                n_fail++; $display("FAIL reg%0d_unchanged: rdata %h rresp %b, expected %h %b",
                    i, rd, rr, er[31:0], er[33:32]);
            end
        end
    endtask

    task automatic test_bready_stall();
        logic [1:0] resp, first, eb; int lat; bit to;
        sb_write(32'h10, 32'h12345678, 4'hF);
        eb = pop_b();
        s_axil_awaddr = 32'h10; s_axil_wdata = 32'h12345678; s_axil_wstrb = 4'hF;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_bready = 1'b0;
        @(posedge s_clk); #1;
        s_axil_wvalid = 1'b0;
        s_axil_awaddr = 32'h14;
        first = s_axil_bresp;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if ({s_axil_bvalid, s_axil_bresp, s_axil_awready, s_axil_wready} !== {1'b1, eb, 2'b00}) begin
                n_fail++; $display("FAIL stall_cycle%0d: bvalid %b bresp %b awready %b wready %b, expected 1 %b 0 0",
                    i, s_axil_bvalid, s_axil_bresp, s_axil_awready, s_axil_wready, eb);
            end
            if (i < 5) begin @(posedge s_clk); #1; end
        end
        n_cmp++;
        if (s_axil_bresp !== first) begin
            n_fail++; $display("FAIL stall_bresp_stable: bresp %b, expected %b", s_axil_bresp, first);
        end
        s_axil_bready = 1'b1;
        @(posedge s_clk); #1;
        s_axil_bready = 1'b0; s_axil_awvalid = 1'b0;
        n_cmp++;
        if ({s_axil_bvalid, s_axil_awready} !== 2'b01) begin
            n_fail++; $display("FAIL stall_release: bvalid %b awready %b, expected 0 1", s_axil_bvalid, s_axil_awready);
        end
        sb_write(32'h14, 32'h0BADF00D, 4'hF);
        do_write(32'h14, 32'h0BADF00D, 4'hF, 0, resp, lat, to);
        eb = pop_b();
        n_cmp++;
        if (to || resp !== eb) begin
            n_fail++; $display("FAIL wr14_after_stall: bresp %b timeout %0d, expected %b", resp, to, eb);
        end
    endtask

    task automatic test_collision();
        logic [1:0] resp, rr, eb; logic [31:0] rd; logic [33:0] er; int lat; bit to;
        sb_write(32'h0C, 32'h01010101, 4'hF);
        do_write(32'h0C, 32'h01010101, 4'hF, 0, resp, lat, to);
        eb = pop_b();
        n_cmp++;
        if (to || resp !== eb) begin
            n_fail++; $display("FAIL coll_prewrite: bresp %b timeout %0d, expected %b", resp, to, eb);
        end
        n_cmp++;
        if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b111) begin
            n_fail++; $display("FAIL coll_ready: got %b expected 111", {s_axil_awready, s_axil_wready, s_axil_arready});
        end
        sb_read(32'h0C);
        sb_write(32'h0C, 32'h5A5A5A5A, 4'hF);
        s_axil_awaddr = 32'h0C; s_axil_wdata = 32'h5A5A5A5A; s_axil_wstrb = 4'hF; s_axil_araddr = 32'h0C;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
        @(posedge s_clk); #1;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
        n_cmp++;
        if ({s_axil_bvalid, s_axil_rvalid} !== 2'b11) begin
            n_fail++; $display("FAIL coll_valids: bvalid %b rvalid %b, expected 1 1", s_axil_bvalid, s_axil_rvalid);
        end
        rd = s_axil_rdata; rr = s_axil_rresp; resp = s_axil_bresp;
        s_axil_bready = 1'b1; s_axil_rready = 1'b1;
        @(posedge s_clk); #1;
        s_axil_bready = 1'b0; s_axil_rready = 1'b0;
        er = pop_r();
        n_cmp++;
        if ({rr, rd} !== er) begin
            n_fail++; $display("FAIL coll_old_value: rdata %h rresp %b, expected %h %b", rd, rr, er[31:0], er[33:32]);
        end
        eb = pop_b();
        n_cmp++;
        if (resp !== eb) begin
            n_fail++; $display("FAIL coll_bresp: bresp %b, expected %b", resp, eb);
        end
        sb_read(32'h0C);
        do_read(32'h0C, rd, rr, lat, to);
        er = pop_r();
        n_cmp++;
        if (to || {rr, rd} !== er) begin
            n_fail++; $display("FAIL coll_new_value: rdata %h rresp %b, expected %h %b", rd, rr, er[31:0], er[33:32]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        logic [33:0] er;
        int a, last, nresp;
        bit hs;
        addrs = '{32'h00, 32'h04, 32'h10, 32'h0C};
        a = 0; last = -1; nresp = 0;
        s_axil_rready = 1'b1; s_axil_araddr = addrs[0]; s_axil_arvalid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            hs = s_axil_arvalid && s_axil_arready;
            if (hs) sb_read(addrs[a]);
            if (s_axil_rvalid) begin
                er = pop_r();
                nresp++;
                n_cmp++;
                if ({s_axil_rresp, s_axil_rdata} !== er) begin
                    n_fail++; $display("FAIL b2b_data%0d: rdata %h rresp %b, expected %h %b",
                        nresp, s_axil_rdata, s_axil_rresp, er[31:0], er[33:32]);
                end
                if (last >= 0) begin
                    n_cmp++;
                    if (c - last != 2) begin
                        n_fail++; $display("FAIL b2b_spacing%0d: %0d cycles, expected 2", nresp, c - last);
                    end
                end
                last = c;
            end
            @(posedge s_clk); #1;
            if (hs) begin
                a++;
                if (a == 4) s_axil_arvalid = 1'b0;
                else s_axil_araddr = addrs[a];
            end
        end
        s_axil_rready = 1'b0; s_axil_arvalid = 1'b0;
        n_cmp++;
        if (nresp != 4) begin
            n_fail++; $display("FAIL b2b_count: %0d responses, expected 4", nresp);
        end
    endtask

    task automatic test_reset_midflight();
        logic [1:0] rr; logic [31:0] rd; logic [33:0] er; int lat; bit to;
        s_axil_awaddr = 32'h04; s_axil_awvalid = 1'b1;
        s_axil_araddr = 32'h04; s_axil_arvalid = 1'b1;
        @(posedge s_clk); #1;
        s_axil_awvalid = 1'b0; s_axil_arvalid = 1'b0;
        n_cmp++;
        if ({s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_rvalid} !== 4'b0101) begin
            n_fail++; $display("FAIL midflight_state: aw %b w %b b %b r %b, expected 0 1 0 1",
                s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_rvalid);
        end
        s_axil_wdata = 32'h77777777; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
        s_rst = 1'b0;
        #1;
        n_cmp++;
        if ({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid,
             s_axil_bresp, s_axil_rresp, s_axil_rdata} !== 41'd0) begin
            n_fail++; $display("FAIL midflight_reset_outputs: aw%b w%b ar%b b%b r%b rdata %h, expected all 0",
                s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid, s_axil_rdata);
        end
        s_axil_wvalid = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        @(posedge s_clk); #1;
        s_rst = 1'b1;
        @(posedge s_clk); #1;
        for (int i = 0; i < 2; i++) begin
            sb_read(32'(4 + 4 * i));
            do_read(32'(4 + 4 * i), rd, rr, lat, to);
            er = pop_r();
            n_cmp++;
            if (to || {rr, rd} !== er) begin
                n_fail++; $display("FAIL post_reset_rd%0d: rdata %h rresp %b, expected %h %b",
                    4 + 4 * i, rd, rr, er[31:0], er[33:32]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        s_rst = 1'b0;
        s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_awvalid = 1'b0;
        s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0; s_axil_bready = 1'b0;
        s_axil_araddr = '0; s_axil_arprot = '0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;

        test_reset();
        test_same_cycle_write();
        test_aw_before_w();
        test_out_of_range();
        test_bready_stall();
        test_collision();
        test_back_to_back();
        test_reset_midflight();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
